timer_apb_regs: RTL and testbench

//  APB3 slave register file driving the 8-bit timer (TCNT_sum) and collecting its events.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/apb_slave_fsm.sv | 86 ++++++++
 rtl/timer_apb_regs.sv | 97 +++++++++
 tb/tb_timer_apb_regs.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer APB register block: register map, control/status
// bit positions and the APB slave state encoding.
package timer_pkg;

    localparam logic [1:0] ADDR_TDR  = 2'd0;
    localparam logic [1:0] ADDR_TCR  = 2'd1;
    localparam logic [1:0] ADDR_TSR  = 2'd2;
    localparam logic [1:0] ADDR_TCNT = 2'd3;

    localparam int TCR_LOAD = 7;
    localparam int TCR_DOWN = 5;
    localparam int TCR_EN   = 4;

    localparam int TSR_OVF  = 0;
    localparam int TSR_UNDF = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_slave_fsm.sv
// APB3 transfer sequencer: tracks IDLE/SETUP/ACCESS, inserts WAIT_CYCLES wait states
// and produces a registered PREADY plus the one-cycle read/write strobes.
//
// state  | meaning
// IDLE   | no transfer in progress
// SETUP  | setup phase seen, expecting PENABLE=1
// ACCESS | access phase, counting wait states until PREADY
module apb_slave_fsm
    import timer_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 8
) (
    input  logic              PCLK,
    input  logic              RST_n,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-3:0] paddr_hi,
    output logic              PREADY,
    output logic              wr_en,
    output logic              rd_en,
    output logic              addr_err
);

    localparam logic [2:0] WAIT_LIM = 3'(WAIT_CYCLES);

    apb_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) state_d = SETUP;
            end
            SETUP: begin
                if (PSEL && PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = 3'd0;
                    ready_d = (WAIT_LIM == 3'd0);
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (ready_q) begin
                    cnt_d   = 3'd0;
                    state_d = (!PENABLE) ? SETUP : IDLE;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    ready_d = ((cnt_q + 3'd1) == WAIT_LIM);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // A PSEL drop during the ready cycle must not produce a strobe.
    assign PREADY   = ready_q && PSEL;
    assign wr_en    = PREADY && PWRITE;
    assign rd_en    = PREADY && !PWRITE;
    assign addr_err = |paddr_hi;

endmodule

// File: rtl/timer_apb_regs.sv
// APB3 register file for the 8-bit timer: TDR/TCR drive lines, sticky W1C event flags
// in TSR and read-only access to the live counter value.
module timer_apb_regs
    import timer_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 8
) (
    input  logic              PCLK,
    input  logic              RST_n,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [7:0]        PWDATA,
    output logic [7:0]        PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [7:0]        tcnt_val,
    input  logic              over_flow,
    input  logic              under_flow,
    output logic [7:0]        TDR,
    output logic [7:0]        TCR,
    output logic [1:0]        Clk_SEL
);

    logic       wr_en, rd_en, addr_err;
    logic [1:0] reg_sel;
    logic       ro_err;
    logic [7:0] tdr_q, tdr_d;
    logic [7:0] tcr_q, tcr_d;
    logic [1:0] tsr_q, tsr_d;

    apb_slave_fsm #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .ADDR_W     (ADDR_W)
    ) u_fsm (
        .PCLK    (PCLK),
        .RST_n   (RST_n),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .paddr_hi(PADDR[ADDR_W-1:2]),
        .PREADY  (PREADY),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .addr_err(addr_err)
    );

    assign reg_sel = PADDR[1:0];
    assign ro_err  = PWRITE && (reg_sel == ADDR_TCNT);
    assign PSLVERR = PREADY && (addr_err || ro_err);

    always_comb begin
        tdr_d  = tdr_q;
        tcr_d  = tcr_q;
        tsr_d  = tsr_q;
        PRDATA = 8'h00;
        if (wr_en && !addr_err) begin
            case (reg_sel)
                ADDR_TDR: tdr_d = PWDATA;
                ADDR_TCR: tcr_d = PWDATA;
                ADDR_TSR: tsr_d = tsr_q & ~PWDATA[1:0];
                default:  ;
            endcase
        end
        // Events are applied after the clear so a coincident event keeps its flag set.
        if (over_flow)  tsr_d[TSR_OVF]  = 1'b1;
        if (under_flow) tsr_d[TSR_UNDF] = 1'b1;
        if (rd_en && !addr_err) begin
            case (reg_sel)
                ADDR_TDR:  PRDATA = tdr_q;
                ADDR_TCR:  PRDATA = tcr_q;
                ADDR_TSR:  PRDATA = {6'b0, tsr_q};
                ADDR_TCNT: PRDATA = tcnt_val;
                default:   PRDATA = 8'h00;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge RST_n) begin
        if (!RST_n) begin
            tdr_q <= 8'h00;
            tcr_q <= 8'h00;
            tsr_q <= 2'b00;
        end else begin
            tdr_q <= tdr_d;
            tcr_q <= tcr_d;
            tsr_q <= tsr_d;
        end
    end

    assign TDR     = tdr_q;
    assign TCR     = tcr_q;
    assign Clk_SEL = tcr_q[1:0];

endmodule

// File: tb/tb_timer_apb_regs.sv
// Scoreboard bench for timer_apb_regs: transfers push expected responses, a negedge
// monitor pops and checks them whenever PREADY is seen.
module tb_timer_apb_regs;

    logic       PCLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0] PADDR = 8'h00, PWDATA = 8'h00;
    logic [7:0] PRDATA;
    logic       PREADY, PSLVERR;
    logic [7:0] tcnt_val = 8'h00;
    logic       over_flow = 1'b0, under_flow = 1'b0;
    logic [7:0] TDR, TCR;
    logic [1:0] Clk_SEL;
    logic       tcnt_run = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_rd;
        bit         use_tcnt;
        logic [7:0] rdata;
        bit         err;
    } exp_t;
    exp_t sb[$];

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) if (tcnt_run) tcnt_val <= tcnt_val + 8'd3;

    timer_apb_regs #(.WAIT_CYCLES(1), .ADDR_W(8)) dut (
        .PCLK(PCLK), .RST_n(RST_n), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tcnt_val(tcnt_val), .over_flow(over_flow), .under_flow(under_flow),
        .TDR(TDR), .TCR(TCR), .Clk_SEL(Clk_SEL)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge PCLK) begin
        if (RST_n && PREADY) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pready: got PREADY=1 expected no pending transfer");
            end else begin
                e = sb.pop_front();
                if (PSLVERR !== e.err) begin
                    bad++;
                    $display("FAIL pslverr: got %b expected %b", PSLVERR, e.err);
                end
                if (e.is_rd) begin
                    logic [7:0] want;
                    want = e.use_tcnt ? tcnt_val : e.rdata;
                    total++;
                    if (PRDATA !== want) begin
                        bad++;
                        $display("FAIL prdata: got %h expected %h", PRDATA, want);
                    end
                end
            end
        end
    end

    // One full transfer; ev pulses over_flow across the whole access phase.
    task automatic apb(input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input bit exp_err,
                       input bit use_tcnt, input bit ev);
        exp_t e;
        int n;
        e.is_rd = !wr; e.use_tcnt = use_tcnt; e.rdata = exp_rd; e.err = exp_err;
        sb.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (ev) over_flow = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!PREADY && n < 20);
        chk("pready_latency", 8'(n), 8'd3);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; over_flow = 1'b0;
    endtask

    initial begin
        // Reset
        #20;
        chk("rst_tdr", TDR, 8'h00);
        chk("rst_tcr", TCR, 8'h00);
        chk("rst_outs", {3'b0, PREADY, PSLVERR, Clk_SEL, 1'b0} | PRDATA, 8'h00);
        RST_n = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        chk("post_rst_tdr", TDR, 8'h00);
        chk("post_rst_ready", {7'b0, PREADY}, 8'h00);

        // Basic writes and readback
        apb(1, 8'h00, 8'hDF, 8'h00, 0, 0, 0);
        chk("tdr_wr", TDR, 8'hDF);
        apb(1, 8'h01, 8'h90, 8'h00, 0, 0, 0);
        chk("tcr_wr", TCR, 8'h90);
        chk("clk_sel", {6'b0, Clk_SEL}, 8'h00);
        apb(0, 8'h00, 8'h00, 8'hDF, 0, 0, 0);
        apb(0, 8'h01, 8'h00, 8'h90, 0, 0, 0);
        apb(1, 8'h01, 8'h13, 8'h00, 0, 0, 0);
        chk("clk_sel_3", {6'b0, Clk_SEL}, 8'h03);

        // Sticky flags
        @(posedge PCLK); #1; over_flow = 1'b1;
        @(posedge PCLK); #1; over_flow = 1'b0;
        apb(0, 8'h02, 8'h00, 8'h01, 0, 0, 0);
        apb(1, 8'h02, 8'h01, 8'h00, 0, 0, 0);
        apb(0, 8'h02, 8'h00, 8'h00, 0, 0, 0);
        apb(1, 8'h02, 8'h01, 8'h00, 0, 0, 1);
        apb(0, 8'h02, 8'h00, 8'h01, 0, 0, 0);
        @(posedge PCLK); #1; under_flow = 1'b1;
        @(posedge PCLK); #1; under_flow = 1'b0;
        apb(0, 8'h02, 8'h00, 8'h03, 0, 0, 0);
        apb(1, 8'h02, 8'hFF, 8'h00, 0, 0, 0);
        apb(0, 8'h02, 8'h00, 8'h00, 0, 0, 0);

        // Live counter readback, read-only error
        tcnt_run = 1'b1;
        apb(0, 8'h03, 8'h00, 8'h00, 0, 1, 0);
        apb(1, 8'h03, 8'h77, 8'h00, 1, 0, 0);
        tcnt_run = 1'b0;

        // Bad addresses
        apb(0, 8'h04, 8'h00, 8'h00, 1, 0, 0);
        apb(1, 8'h80, 8'hAA, 8'h00, 1, 0, 0);
        apb(1, 8'h81, 8'hAA, 8'h00, 1, 0, 0);
        chk("err_no_tdr_change", TDR, 8'hDF);
        chk("err_no_tcr_change", TCR, 8'h13);

        // PSEL dropped before PREADY: no write
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 8'h3C;
        @(posedge PCLK); #1; PENABLE = 1'b1;
        @(posedge PCLK); #1; PSEL = 1'b0; PENABLE = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("abort_no_write", TDR, 8'hDF);

        // Reset during access phase of a write
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 8'h55;
        @(posedge PCLK); #1; PENABLE = 1'b1;
        @(posedge PCLK); #1; RST_n = 1'b0;
        #1;
        chk("rst_mid_tdr", TDR, 8'h00);
        chk("rst_mid_ready", {7'b0, PREADY}, 8'h00);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1; RST_n = 1'b1;
        chk("rst_mid_tdr_after", TDR, 8'h00);
        apb(1, 8'h00, 8'h12, 8'h00, 0, 0, 0);
        apb(0, 8'h00, 8'h00, 8'h12, 0, 0, 0);

        repeat (3) @(posedge PCLK);
        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
